// File: rtl/uart_tx_fifo_if.sv
// Bus-side signal bundle for uart_tx_fifo: CPU store strobe, write data,
// overflow clear, status word, completion pulse and an FSM debug view.
interface uart_tx_fifo_if;
    // EN is a one-cycle write strobe with no backpressure: a byte offered while
    // status_o[9] (full) is high is dropped and flagged in status_o[11].
    logic        EN;
    logic [31:0] P_Data;
    logic        clr_ovf;
    logic [31:0] status_o;
    logic        irq_o;
    logic [2:0]  dbg_state;

    modport master (
        output EN, P_Data, clr_ovf,
        input  status_o, irq_o, dbg_state
    );

    modport slave (
        input  EN, P_Data, clr_ovf,
        output status_o, irq_o, dbg_state
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx_fifo #(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    uart_tx_fifo_if.slave  bus,
    output logic           txd
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLK_DIV);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3
    } state_t;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d, empty_q, empty_d, ovf_q, ovf_d;
    logic          push, drop, pop;
    logic [7:0]    head;

    state_t        state_q;
    logic          txd_q, irq_q, busy_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic [BW-1:0] baud_q;
    logic          bit_end;
`ifdef UART_TX_PARITY_EN
    logic          parity_q;
`endif

    logic unused_pdata;
    assign unused_pdata = ^bus.P_Data[31:8];

    // Write acceptance uses the registered full flag, so a same-cycle pop never rescues a write.
    assign push    = bus.EN && !full_q;
    assign drop    = bus.EN && full_q;
    assign pop     = (state_q == S_IDLE) && !empty_q;
    assign head    = mem_q[rd_ptr_q];
    assign bit_end = (baud_q == BW'(CLK_DIV - 1));

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        full_d   = (count_d == CW'(FIFO_DEPTH));
        empty_d  = (count_d == '0);
        ovf_d    = ovf_q;
        if (bus.clr_ovf) ovf_d = 1'b0;
        if (drop)        ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.P_Data[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            txd_q     <= 1'b1;
            irq_q     <= 1'b0;
            busy_q    <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            baud_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            irq_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_q   <= head;
                        bit_cnt_q <= '0;
                        baud_q    <= '0;
                        txd_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_START;
`ifdef UART_TX_PARITY_EN
                        parity_q  <= ^head;
`endif
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        txd_q   <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_q    <= '0;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            txd_q   <= parity_q;
                            state_q <= S_PARITY;
`else
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            // shift_q[1] is the bit that becomes LSB after this edge's shift.
                            txd_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        txd_q   <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        busy_q  <= 1'b0;
                        irq_q   <= empty_q;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + BW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign txd           = txd_q;
    assign bus.irq_o     = irq_q;
    assign bus.dbg_state = state_q;
    assign bus.status_o  = {20'd0, ovf_q, busy_q, full_q, empty_q, 8'(count_q)};
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a mid-bit-sampling UART receiver model
// decodes txd, and each scenario task compares against its own expectations.
module tb_uart_tx_fifo;
    localparam int CLK_DIV = 4;
    localparam int DEPTH   = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = CLK_DIV * NBITS;

    logic clk;
    logic rst;
    logic txd;
    uart_tx_fifo_if bus_if();

    uart_tx_fifo #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if),
        .txd (txd)
    );

    int checks;
    int failures;
    int cyc;

    logic [7:0] exp_q[$];
    logic [7:0] rx_byte_q[$];
    int         rx_start_q[$];
    logic       rx_par_q[$];
    int         irq_cyc_q[$];
    int         rx_err;

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    // receiver model: on a falling txd, sample each bit in its middle
    initial begin
        bit         rx_active;
        int         rx_off;
        int         rx_start;
        logic [10:0] rx_bits;
        logic [3:0]  bidx;
        rx_active = 1'b0;
        rx_off    = 0;
        rx_start  = 0;
        rx_bits   = '0;
        rx_err    = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rx_active = 1'b0;
            end else begin
                if (bus_if.irq_o === 1'b1) irq_cyc_q.push_back(cyc);
                if (!rx_active) begin
                    if (txd === 1'b0) begin
                        rx_active = 1'b1;
                        rx_off    = 0;
                        rx_start  = cyc;
                    end
                end else begin
                    rx_off++;
                    if ((rx_off % CLK_DIV) == (CLK_DIV / 2)) begin
                        bidx = 4'(rx_off / CLK_DIV);
                        rx_bits[bidx] = txd;
                        if (int'(bidx) == NBITS - 1) begin
                            if (rx_bits[0] !== 1'b0 || txd !== 1'b1) rx_err++;
                            rx_byte_q.push_back(rx_bits[8:1]);
                            rx_start_q.push_back(rx_start);
                            rx_par_q.push_back(rx_bits[9]);
                            rx_active = 1'b0;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [10:0] frame_bits(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b11, b, 1'b0};
`endif
    endfunction

    // driver tasks
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] b);
        bus_if.EN     = 1'b1;
        bus_if.P_Data = {24'($urandom), b};
        tick();
        bus_if.EN     = 1'b0;
    endtask

    task automatic flush;
        exp_q.delete();
        rx_byte_q.delete();
        rx_start_q.delete();
        rx_par_q.delete();
        irq_cyc_q.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (!(bus_if.status_o[10] == 1'b0 && bus_if.status_o[8] == 1'b1) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL wait_idle timeout status=%h budget=%0d", bus_if.status_o, budget);
        end
        repeat (2) tick();
    endtask

    // scoreboard: compare everything the receiver decoded against exp_q
    task automatic score(input string name, input int exp_irqs);
        checks++;
        if (rx_byte_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s frame_count got=%0d exp=%0d", name, rx_byte_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_byte_q[i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL %s byte[%0d] got=%h exp=%h", name, i, rx_byte_q[i], exp_q[i]);
                end
`ifdef UART_TX_PARITY_EN
                checks++;
                if (rx_par_q[i] !== ^exp_q[i]) begin
                    failures++;
                    $display("FAIL %s parity[%0d] got=%b exp=%b", name, i, rx_par_q[i], ^exp_q[i]);
                end
`endif
            end
        end
        checks++;
        if (irq_cyc_q.size() != exp_irqs) begin
            failures++;
            $display("FAIL %s irq_count got=%0d exp=%0d", name, irq_cyc_q.size(), exp_irqs);
        end
        checks++;
        if (rx_err != 0) begin
            failures++;
            $display("FAIL %s framing_errors got=%0d exp=0", name, rx_err);
        end
    endtask

    task automatic test_reset;
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL reset_txd got=%b exp=1", txd); end
        checks++;
        if (bus_if.status_o !== 32'h100) begin failures++; $display("FAIL reset_status got=%h exp=00000100", bus_if.status_o); end
        checks++;
        if (bus_if.irq_o !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus_if.irq_o); end
        rst = 1'b0;
        repeat (2) tick();
        bus_write(8'h5A);
        repeat (12) tick();
        checks++;
        if (txd === 1'b1 && bus_if.status_o[10] !== 1'b1) begin
            failures++;
            $display("FAIL reset_prefame_busy got=%b exp=1", bus_if.status_o[10]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL reset_async_txd got=%b exp=1", txd); end
        checks++;
        if (bus_if.status_o !== 32'h100) begin failures++; $display("FAIL reset_async_status got=%h exp=00000100", bus_if.status_o); end
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (bus_if.status_o !== 32'h100) begin failures++; $display("FAIL reset_after_status got=%h exp=00000100", bus_if.status_o); end
        checks++;
        if (bus_if.irq_o !== 1'b0) begin failures++; $display("FAIL reset_after_irq got=%b exp=0", bus_if.irq_o); end
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL reset_after_txd got=%b exp=1", txd); end
        flush();
    endtask

    task automatic test_single_byte;
        logic [10:0] fb;
        flush();
        fb = frame_bits(8'h55);
        bus_write(8'h55);
        exp_q.push_back(8'h55);
        checks++;
        if (bus_if.status_o[7:0] !== 8'd1) begin failures++; $display("FAIL single_count_k got=%0d exp=1", bus_if.status_o[7:0]); end
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL single_txd_k got=%b exp=1", txd); end
        tick();
        checks++;
        if (bus_if.status_o[7:0] !== 8'd0) begin failures++; $display("FAIL single_count_k1 got=%0d exp=0", bus_if.status_o[7:0]); end
        checks++;
        if (bus_if.status_o[10] !== 1'b1) begin failures++; $display("FAIL single_busy_k1 got=%b exp=1", bus_if.status_o[10]); end
        for (int i = 0; i < FL; i++) begin
            if (i > 0) tick();
            checks++;
            if (txd !== fb[i / CLK_DIV]) begin
                failures++;
                $display("FAIL single_txd_cycle%0d got=%b exp=%b", i, txd, fb[i / CLK_DIV]);
            end
        end
        tick();
        checks++;
        if (bus_if.irq_o !== 1'b1) begin failures++; $display("FAIL single_irq_pulse got=%b exp=1", bus_if.irq_o); end
        checks++;
        if (bus_if.status_o[10] !== 1'b0) begin failures++; $display("FAIL single_busy_end got=%b exp=0", bus_if.status_o[10]); end
        checks++;
        if (txd !== 1'b1) begin failures++; $display("FAIL single_txd_idle got=%b exp=1", txd); end
        tick();
        checks++;
        if (bus_if.irq_o !== 1'b0) begin failures++; $display("FAIL single_irq_width got=%b exp=0", bus_if.irq_o); end
        tick();
        score("single", 1);
    endtask

    task automatic test_back_to_back;
        flush();
        bus_write(8'hA3);
        bus_write(8'h0F);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        repeat (3 * CLK_DIV) tick();
        checks++;
        if (bus_if.status_o[7:0] !== 8'd1) begin failures++; $display("FAIL b2b_count_frame1 got=%0d exp=1", bus_if.status_o[7:0]); end
        wait_idle(3 * FL);
        score("b2b", 1);
        if (rx_start_q.size() == 2 && irq_cyc_q.size() == 1) begin
            checks++;
            if (rx_start_q[1] - rx_start_q[0] != FL + 1) begin
                failures++;
                $display("FAIL b2b_gap got=%0d exp=%0d", rx_start_q[1] - rx_start_q[0], FL + 1);
            end
            checks++;
            if (irq_cyc_q[0] - rx_start_q[1] != FL) begin
                failures++;
                $display("FAIL b2b_irq_time got=%0d exp=%0d", irq_cyc_q[0] - rx_start_q[1], FL);
            end
        end
    endtask

    task automatic test_overflow;
        logic [7:0] b;
        flush();
        b = 8'($urandom);
        bus_write(b);
        exp_q.push_back(b);
        tick();
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            bus_write(b);
            if (i < DEPTH) exp_q.push_back(b);
        end
        checks++;
        if (bus_if.status_o[7:0] !== 8'(DEPTH)) begin failures++; $display("FAIL ovf_count got=%0d exp=%0d", bus_if.status_o[7:0], DEPTH); end
        checks++;
        if (bus_if.status_o[9:8] !== 2'b10) begin failures++; $display("FAIL ovf_full_empty got=%b exp=10", bus_if.status_o[9:8]); end
        checks++;
        if (bus_if.status_o[11] !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus_if.status_o[11]); end
        bus_if.clr_ovf = 1'b1;
        tick();
        bus_if.clr_ovf = 1'b0;
        checks++;
        if (bus_if.status_o[11] !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", bus_if.status_o[11]); end
        bus_if.clr_ovf = 1'b1;
        bus_write(8'($urandom));
        bus_if.clr_ovf = 1'b0;
        checks++;
        if (bus_if.status_o[11] !== 1'b1) begin failures++; $display("FAIL ovf_clr_and_set got=%b exp=1", bus_if.status_o[11]); end
        checks++;
        if (bus_if.status_o[7:0] !== 8'(DEPTH)) begin failures++; $display("FAIL ovf_count_hold got=%0d exp=%0d", bus_if.status_o[7:0], DEPTH); end
        bus_if.clr_ovf = 1'b1;
        tick();
        bus_if.clr_ovf = 1'b0;
        wait_idle((DEPTH + 2) * (FL + 1));
        score("overflow", 1);
        checks++;
        if (bus_if.status_o !== 32'h100) begin failures++; $display("FAIL ovf_final_status got=%h exp=00000100", bus_if.status_o); end
    endtask

    task automatic test_push_pop_wrap;
        logic [7:0] b;
        logic [7:0] c;
        int n;
        flush();
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            bus_write(b);
            exp_q.push_back(b);
        end
        checks++;
        if (bus_if.status_o[7:0] !== 8'd1) begin failures++; $display("FAIL wrap_initial_count got=%0d exp=1", bus_if.status_o[7:0]); end
        for (int k = 0; k < 10; k++) begin
            n = 0;
            while (bus_if.status_o[10] !== 1'b0 && n < FL + 4) begin
                tick();
                n++;
            end
            checks++;
            if (n >= FL + 4) begin
                failures++;
                $display("FAIL wrap_wait_idle k=%0d status=%h", k, bus_if.status_o);
            end
            c = bus_if.status_o[7:0];
            b = 8'($urandom);
            bus_write(b);
            exp_q.push_back(b);
            checks++;
            if (bus_if.status_o[7:0] !== c) begin failures++; $display("FAIL wrap_pushpop_count k=%0d got=%0d exp=%0d", k, bus_if.status_o[7:0], c); end
            checks++;
            if (bus_if.status_o[10] !== 1'b1) begin failures++; $display("FAIL wrap_busy k=%0d got=%b exp=1", k, bus_if.status_o[10]); end
        end
        wait_idle(3 * FL);
        score("wrap", 1);
    endtask

    task automatic test_random_bursts;
        int len;
        logic [7:0] b;
        for (int r = 0; r < 6; r++) begin
            flush();
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                bus_write(b);
                exp_q.push_back(b);
            end
            wait_idle((len + 2) * (FL + 1));
            score("burst", 1);
            for (int i = 1; i < rx_start_q.size(); i++) begin
                checks++;
                if (rx_start_q[i] - rx_start_q[i-1] != FL + 1) begin
                    failures++;
                    $display("FAIL burst_gap[%0d] got=%0d exp=%0d", i, rx_start_q[i] - rx_start_q[i-1], FL + 1);
                end
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        logic [7:0] pv [2];
        logic       pe [2];
        pv[0] = 8'h07; pe[0] = 1'b1;
        pv[1] = 8'h03; pe[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            flush();
            bus_write(pv[i]);
            exp_q.push_back(pv[i]);
            wait_idle(2 * FL);
            score("parity", 1);
            if (rx_par_q.size() == 1 && irq_cyc_q.size() == 1) begin
                checks++;
                if (rx_par_q[0] !== pe[i]) begin failures++; $display("FAIL parity_bit_%h got=%b exp=%b", pv[i], rx_par_q[0], pe[i]); end
                checks++;
                if (irq_cyc_q[0] - rx_start_q[0] != 11 * CLK_DIV) begin
                    failures++;
                    $display("FAIL parity_frame_len got=%0d exp=%0d", irq_cyc_q[0] - rx_start_q[0], 11 * CLK_DIV);
                end
            end
        end
    endtask
`endif

    initial begin
        checks         = 0;
        failures       = 0;
        rst            = 1'b1;
        bus_if.EN      = 1'b0;
        bus_if.P_Data  = '0;
        bus_if.clr_ovf = 1'b0;
        repeat (3) tick();
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_push_pop_wrap();
        test_random_bursts();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
